// File: rtl/afifo_16i_64o_512.sv
// 16-bit in / 256-bit out FIFO sharing one clock; rd_data registered one cycle after an accepted read.
// No backpressure beyond flags: writes ignored while wr_full, reads ignored while rd_empty.
module afifo_16i_64o_512 #(
  parameter int WR_DEPTH_WIDTH   = 12,
  parameter int WR_DATA_WIDTH    = 16,
  parameter int RD_DEPTH_WIDTH   = 8,
  parameter int RD_DATA_WIDTH    = 256,
  parameter int ALMOST_FULL_NUM  = 4092,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                      wr_clk,
  input  logic                      rd_clk,
  input  logic                      wr_rst,
  input  logic                      rd_rst,
  input  logic [WR_DATA_WIDTH-1:0]  wr_data,
  input  logic                      wr_en,
  output logic                      wr_full,
  output logic [WR_DEPTH_WIDTH:0]   wr_water_level,
  output logic                      almost_full,
  output logic [RD_DATA_WIDTH-1:0]  rd_data,
  input  logic                      rd_en,
  output logic                      rd_empty,
  output logic [RD_DEPTH_WIDTH:0]   rd_water_level,
  output logic                      almost_empty
);

  localparam int LANES  = RD_DATA_WIDTH / WR_DATA_WIDTH;
  localparam int LANE_W = WR_DEPTH_WIDTH - RD_DEPTH_WIDTH;
  localparam int ROWS   = 1 << RD_DEPTH_WIDTH;
  localparam logic [WR_DEPTH_WIDTH:0] AF_NUM = ALMOST_FULL_NUM[WR_DEPTH_WIDTH:0];
  localparam logic [RD_DEPTH_WIDTH:0] AE_NUM = ALMOST_EMPTY_NUM[RD_DEPTH_WIDTH:0];
  localparam logic [WR_DEPTH_WIDTH:0] WR_ONE = {{WR_DEPTH_WIDTH{1'b0}}, 1'b1};
  localparam logic [RD_DEPTH_WIDTH:0] RD_ONE = {{RD_DEPTH_WIDTH{1'b0}}, 1'b1};

  logic                      rst;
  logic [WR_DEPTH_WIDTH:0]   wr_ptr;
  logic [RD_DEPTH_WIDTH:0]   rd_ptr;
  logic [WR_DEPTH_WIDTH:0]   occ;
  logic                      wr_accept;
  logic                      rd_accept;
  logic [RD_DATA_WIDTH-1:0]  rd_word;
  logic [WR_DATA_WIDTH-1:0]  mem [LANES][ROWS];

  // Either reset clears both sides, so the two pointers never disagree about what is stored.
  assign rst = wr_rst | rd_rst;

  // Read pointer counts whole read words; scale it into write-word units.
  assign occ            = wr_ptr - {rd_ptr, {LANE_W{1'b0}}};
  assign wr_water_level = occ;
  assign wr_full        = occ[WR_DEPTH_WIDTH];
  assign almost_full    = (occ >= AF_NUM);
  assign rd_water_level = occ[WR_DEPTH_WIDTH:LANE_W];
  assign rd_empty       = (rd_water_level == '0);
  assign almost_empty   = (rd_water_level <= AE_NUM);

  assign wr_accept = wr_en & ~wr_full & ~rst;
  assign rd_accept = rd_en & ~rd_empty & ~rst;

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      wr_ptr <= '0;
    end else if (wr_accept) begin
      wr_ptr <= wr_ptr + WR_ONE;
    end
  end

  // Low pointer bits pick the lane, so word k of a read word lands in bits [16k+15:16k].
  always_ff @(posedge wr_clk) begin
    if (wr_accept) begin
      mem[wr_ptr[LANE_W-1:0]][wr_ptr[WR_DEPTH_WIDTH-1:LANE_W]] <= wr_data;
    end
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < LANES; i++) begin
      rd_word[i*WR_DATA_WIDTH +: WR_DATA_WIDTH] = mem[i][rd_ptr[RD_DEPTH_WIDTH-1:0]];
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      rd_data <= '0;
    end else if (rd_accept) begin
      rd_ptr  <= rd_ptr + RD_ONE;
      rd_data <= rd_word;
    end
  end

endmodule

// File: tb/tb_afifo_16i_64o_512.sv
// Bench for afifo_16i_64o_512: directed boundary sequences plus random traffic
// checked every cycle against a queue-of-words reference model.
module tb_afifo_16i_64o_512;

  logic         clk;
  logic         tb_rst;
  logic [15:0]  wr_data;
  logic         wr_en;
  logic         wr_full;
  logic [12:0]  wr_water_level;
  logic         almost_full;
  logic [255:0] rd_data;
  logic         rd_en;
  logic         rd_empty;
  logic [8:0]   rd_water_level;
  logic         almost_empty;

  int n_checks;
  int n_errors;

  logic [15:0]  model_q[$];
  logic [255:0] exp_rd;

  afifo_16i_64o_512 dut (
    .wr_clk         (clk),
    .rd_clk         (clk),
    .wr_rst         (tb_rst),
    .rd_rst         (tb_rst),
    .wr_data        (wr_data),
    .wr_en          (wr_en),
    .wr_full        (wr_full),
    .wr_water_level (wr_water_level),
    .almost_full    (almost_full),
    .rd_data        (rd_data),
    .rd_en          (rd_en),
    .rd_empty       (rd_empty),
    .rd_water_level (rd_water_level),
    .almost_empty   (almost_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int sz;
    sz = model_q.size();
    check({tag, " wr_full"},        256'(wr_full),        256'(sz == 4096));
    check({tag, " wr_water_level"}, 256'(wr_water_level), 256'(sz));
    check({tag, " almost_full"},    256'(almost_full),    256'(sz >= 4092));
    check({tag, " rd_water_level"}, 256'(rd_water_level), 256'(sz / 16));
    check({tag, " rd_empty"},       256'(rd_empty),       256'(sz < 16));
    check({tag, " almost_empty"},   256'(almost_empty),   256'((sz / 16) <= 4));
    check({tag, " rd_data"},        rd_data,              exp_rd);
  endtask

  // Drive at the falling edge, update the model at the rising edge, check at the next falling edge.
  task automatic step(input string tag, input bit r, input bit we, input logic [15:0] wd, input bit re);
    bit rd_ok;
    bit wr_ok;
    tb_rst  = r;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    @(posedge clk);
    if (r) begin
      model_q.delete();
      exp_rd = '0;
    end else begin
      rd_ok = re && (model_q.size() >= 16);
      wr_ok = we && (model_q.size() < 4096);
      if (rd_ok) begin
        for (int i = 0; i < 16; i++) exp_rd[i*16 +: 16] = model_q.pop_front();
      end
      if (wr_ok) model_q.push_back(wd);
    end
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) step("reset", 1'b1, 1'b1, 16'h5A5A, 1'b1);
  endtask

  initial begin
    logic [255:0] word;
    int pw;
    int pr;
    n_checks = 0;
    n_errors = 0;
    exp_rd   = '0;
    tb_rst   = 1'b1;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    wr_data  = '0;

    do_reset(20);
    check("reset rd_data zero", rd_data, 256'd0);
    check("reset rd_empty", 256'(rd_empty), 256'd1);

    // Fill to full with a descending pattern; the 4097th write must be dropped.
    for (int i = 0; i < 4097; i++) step("fill", 1'b0, 1'b1, 16'(16'hFFFF - i), 1'b0);
    check("fill level", 256'(wr_water_level), 256'd4096);
    check("fill rd level", 256'(rd_water_level), 256'd256);

    step("drain", 1'b0, 1'b0, 16'h0, 1'b1);
    for (int k = 0; k < 16; k++) word[k*16 +: 16] = 16'(16'hFFFF - k);
    check("first read word", rd_data, word);
    for (int i = 1; i < 257; i++) step("drain", 1'b0, 1'b0, 16'h0, 1'b1);
    check("drain empty", 256'(rd_empty), 256'd1);

    // Partial read word must not clear rd_empty.
    do_reset(2);
    for (int i = 0; i < 15; i++) step("partial", 1'b0, 1'b1, 16'(16'h1000 + i), 1'b0);
    check("partial empty", 256'(rd_empty), 256'd1);
    step("partial", 1'b0, 1'b1, 16'h100F, 1'b0);
    check("16th word level", 256'(rd_water_level), 256'd1);

    // Simultaneous write and read with 32 stored.
    do_reset(2);
    for (int i = 1; i <= 32; i++) step("pre32", 1'b0, 1'b1, 16'(i), 1'b0);
    step("wr+rd", 1'b0, 1'b1, 16'(33), 1'b1);
    for (int k = 0; k < 16; k++) word[k*16 +: 16] = 16'(k + 1);
    check("wr+rd word", rd_data, word);
    check("wr+rd wr level", 256'(wr_water_level), 256'd17);

    // Reset mid-stream overrides active requests; only post-reset data comes back.
    do_reset(2);
    for (int i = 0; i < 100; i++) step("pre-rst", 1'b0, 1'b1, 16'(16'hA000 + i), 1'b0);
    do_reset(1);
    for (int i = 0; i < 16; i++) step("post-rst", 1'b0, 1'b1, 16'(16'hB000 + i), 1'b0);
    step("post-rst rd", 1'b0, 1'b0, 16'h0, 1'b1);
    for (int k = 0; k < 16; k++) word[k*16 +: 16] = 16'(16'hB000 + k);
    check("post-rst word", rd_data, word);

    // Random traffic with alternating fill/drain bias and rare resets.
    for (int c = 0; c < 6000; c++) begin
      pw = ((c / 600) % 2 == 0) ? 95 : 60;
      pr = ((c / 600) % 2 == 0) ? 3 : 10;
      step("rand", ($urandom_range(0, 999) == 0),
           ($urandom_range(0, 99) < pw), 16'($urandom), ($urandom_range(0, 99) < pr));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
